fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register for the five-stage MIPS core.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched word into the D-stage IR that feeds the instruction decoder.
- Computes the next PC from the decoder's NPCsel/NPCOp/CMPOp outputs and the D-stage (forwarded) register values. The architectural branch delay slot is kept: no flush.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 1024, instruction-memory depth in words; legal fetch range is [IM_BASE, IM_BASE+4*IM_WORDS).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  from hazard unit; freezes PC and IF/ID
- instr_F  in  32  word read from instruction memory at pc_F (combinational read)
- npc_sel  in  2  from decoder: 0 = PC+4, 1 = branch/jump via npc_op, 2 = register target
- npc_op  in  2  0 = conditional branch (16-bit offset), 1 = 26-bit jump
- cmp_op  in  2  0 = equal (beq); other codes reserved, compare false
- rs_val_D  in  32  forwarded rs value in D
- rt_val_D  in  32  forwarded rt value in D
- pc_F  out  32  current fetch address to instruction memory
- ir_D  out  32  IF/ID instruction register, goes to decoder IR input
- pc_D  out  32  PC of instruction in D
- pc8_D  out  32  pc_D+8, link value for jal/jalr
- cmp_out  out  1  branch-condition result, combinational in D
- addr_err  out  1  sticky: illegal fetch address seen

Behaviour:
- Reset (async, takes effect immediately, mid-operation included):
  - pc_F=PC_RESET, ir_D=0 (sll $0 = nop), pc_D=PC_RESET, addr_err=0.
  - pc8_D follows pc_D and equals PC_RESET+8 during reset.
- Next-PC selection (combinational, from D-stage fields):
  - npc_sel=0 -> pc_F+4.
  - npc_sel=1, npc_op=0 -> if cmp_out: pc_D+4+(sext(ir_D[15:0])<<2), else pc_F+4.
  - npc_sel=1, npc_op=1 -> {pc_D[31:28], ir_D[25:0], 2'b00}.
  - npc_sel=2 -> rs_val_D.
  - npc_sel=3 or npc_op/cmp_op unknown or other -> pc_F+4. X on an input must never propagate into the PC: decode with a default branch.
- Compare: cmp_op=0 -> cmp_out = (rs_val_D==rt_val_D); other codes -> 0.
- Each rising clk with stall=0: pc_F<=NPC; ir_D<=instr_F; pc_D<=pc_F.
- Each rising clk with stall=1: pc_F, ir_D and pc_D hold. NPC is still computed from held D contents.
- Delay slot: the instruction in F when a branch/jump is in D always enters D on the next cycle. Redirect takes effect one cycle after the jump reaches D. Latency from jump in D to target in F: 1 cycle.
- All adds are 32-bit modulo; wrap at 32'hFFFF_FFFC -> 0 is allowed arithmetically but flags addr_err.
- addr_err:
  - Sets on a non-stalled clock edge when NPC[1:0]!=0 or NPC is outside the legal IM range. The bad NPC is still loaded; the core does not trap.
  - Clears only on reset.
- Simultaneous events:
  - stall=1 and a taken branch: the redirect waits; it is applied on the first edge with stall=0.
  - reset dominates stall.

Optional Feature:
- Macro FETCH_COUNT_EN.
- When defined:
  - Adds output port fetch_cnt[31:0].
  - fetch_cnt resets to 0 and increments by 1 on every non-stalled clock edge after reset. It wraps 32'hFFFF_FFFF -> 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then stall=0, npc_sel=0 for 3 cycles -> pc_F sequence 0x3000, 0x3004, 0x3008, 0x300C; ir_D=0 in the first cycle after reset, then the instruction fetched at each prior pc_F.
- beq in D at pc_D=0x3004, imm=0x0003, rs=rt=5 -> cmp_out=1. Delay-slot word (0x3008) enters D, then pc_F=0x3014. Same test with rs=5, rt=6 -> pc_F=0x300C.
- j with ir_D[25:0]=0x0000C10 at pc_D=0x3000 -> next pc_F=0x3040; pc8_D=0x3008 while in D.
- jr with rs_val_D=0x3002, stall held 2 cycles then released -> pc_F holds for 2 cycles, then loads 0x3002; addr_err=1 and stays 1 until reset.
- Reset asserted mid-cycle while pc_F=0x3020 and stall=1 -> outputs return immediately to pc_F=0x3000, ir_D=0, addr_err=0 without a clock edge.
- With FETCH_COUNT_EN: 10 cycles with 3 stalled -> fetch_cnt=7.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decoder/hazard/IM inputs into the IF stage and the IF/ID outputs.
// The master side drives the decoder/IM inputs; fetch_stage sits on the slave side.
interface fetch_stage_if;
    logic        stall;
    logic [31:0] instr_F;
    logic [1:0]  npc_sel;
    logic [1:0]  npc_op;
    logic [1:0]  cmp_op;
    logic [31:0] rs_val_D;
    logic [31:0] rt_val_D;
    logic [31:0] pc_F;
    logic [31:0] ir_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        cmp_out;
    logic        addr_err;

    modport master (
        output stall, instr_F, npc_sel, npc_op, cmp_op, rs_val_D, rt_val_D,
        input  pc_F, ir_D, pc_D, pc8_D, cmp_out, addr_err
    );

    modport slave (
        input  stall, instr_F, npc_sel, npc_op, cmp_op, rs_val_D, rt_val_D,
        output pc_F, ir_D, pc_D, pc8_D, cmp_out, addr_err
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage with IF/ID register, next-PC selection and sticky fetch-address check.
// Optional macro FETCH_COUNT_EN adds the fetch_cnt output (count of non-stalled edges).
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic         clk,
    input  logic         reset,
    fetch_stage_if.slave bus
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]  fetch_cnt
`endif
);
    // 33-bit end bound so a range reaching 2^32 cannot wrap.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

    logic [31:0] r_pc_f;
    logic [31:0] r_ir_d;
    logic [31:0] r_pc_d;
    logic        r_addr_err;

    logic [31:0] w_pc4_f;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_npc;
    logic        w_cmp;
    logic        w_npc_bad;

    assign w_pc4_f  = r_pc_f + 32'd4;
    assign w_br_tgt = r_pc_d + 32'd4 + {{14{r_ir_d[15]}}, r_ir_d[15:0], 2'b00};
    assign w_j_tgt  = {r_pc_d[31:28], r_ir_d[25:0], 2'b00};

    // Branch compare on the forwarded D-stage operands.
    always_comb begin
        w_cmp = 1'b0;
        case (bus.cmp_op)
            2'd0:    w_cmp = (bus.rs_val_D == bus.rt_val_D);
            default: w_cmp = 1'b0;
        endcase
    end

    // Next-PC mux; every unknown or reserved code falls back to sequential fetch.
    always_comb begin
        w_npc = w_pc4_f;
        case (bus.npc_sel)
            2'd0: w_npc = w_pc4_f;
            2'd1: begin
                case (bus.npc_op)
                    2'd0: begin
                        if (w_cmp == 1'b1) begin
                            w_npc = w_br_tgt;
                        end else begin
                            w_npc = w_pc4_f;
                        end
                    end
                    2'd1:    w_npc = w_j_tgt;
                    default: w_npc = w_pc4_f;
                endcase
            end
            2'd2:    w_npc = bus.rs_val_D;
            default: w_npc = w_pc4_f;
        endcase
    end

    assign w_npc_bad = (w_npc[1:0] != 2'b00)
                    || ({1'b0, w_npc} <  {1'b0, IM_BASE})
                    || ({1'b0, w_npc} >= IM_END);

    // PC, IF/ID register and sticky address-error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_f     <= PC_RESET;
            r_ir_d     <= 32'h0000_0000;
            r_pc_d     <= PC_RESET;
            r_addr_err <= 1'b0;
        end else if (!bus.stall) begin
            r_pc_f <= w_npc;
            r_ir_d <= bus.instr_F;
            r_pc_d <= r_pc_f;
            if (w_npc_bad) begin
                r_addr_err <= 1'b1;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] r_fetch_cnt;

    // Free-running count of fetches that actually advanced the pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt <= 32'd0;
        end else if (!bus.stall) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt = r_fetch_cnt;
`endif

    assign bus.pc_F     = r_pc_f;
    assign bus.ir_D     = r_ir_d;
    assign bus.pc_D     = r_pc_d;
    assign bus.pc8_D    = r_pc_d + 32'd8;
    assign bus.cmp_out  = w_cmp;
    assign bus.addr_err = r_addr_err;
endmodule
